// File: rtl/flag_unit_pkg.sv
// rtl/flag_unit_pkg.sv - shared flag-class encodings, NZCV bit indices and condition evaluation
//
// Purpose: constants shared by flag_unit, flag_calc and condition-pass logic.
//   OP_*      : ex_op flag-class encodings
//   FLAG_*    : bit positions inside a {N,Z,C,V} vector
//   keep_mask : flags an op passes through from the committed state
//   cond_pass : evaluates a 4-bit condition code against an NZCV vector
package flag_unit_pkg;

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Bits set here are not produced by the instruction; they are taken from
    // nzcv as it stands on the commit edge.
    function automatic logic [3:0] keep_mask(input logic [1:0] op);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            OP_LOGIC: m[FLAG_V] = 1'b1;
            OP_MUL: begin
                m[FLAG_C] = 1'b1;
                m[FLAG_V] = 1'b1;
            end
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // 0:EQ 1:NE 2:CS 3:CC 4:MI 5:PL 6:VS 7:VC 8:HI 9:LS 10:GE 11:LT 12:GT 13:LE 14:AL 15:NV(never)
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = ~(n ^ v);
            3'd6:    r = ~z & ~(n ^ v);
            default: r = 1'b1;
        endcase
        // Odd codes invert the even code; 1111 inverts "always" into "never".
        return r ^ cond[0];
    endfunction

endpackage

// File: rtl/flag_unit_flag_calc.sv
// rtl/flag_unit_flag_calc.sv - combinational next-NZCV from flag class, result and carries
//
// Ports:
//   op       in  2   flag class (OP_LOGIC/OP_ADD/OP_SUB/OP_MUL)
//   result   in  DW  ALU/multiplier result
//   alu_c    in  1   adder carry-out (sub: NOT borrow)
//   alu_v    in  1   adder overflow
//   shift_c  in  1   barrel-shifter carry-out
//   old_nzcv in  4   flags supplying passthrough bits
//   nzcv     out 4   resulting {N,Z,C,V}
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] result,
    input  logic          alu_c,
    input  logic          alu_v,
    input  logic          shift_c,
    input  logic [3:0]    old_nzcv,
    output logic [3:0]    nzcv
);

    always_comb begin
        nzcv         = old_nzcv;
        nzcv[FLAG_N] = result[DW-1];
        nzcv[FLAG_Z] = (result == '0);
        case (op)
            OP_LOGIC: nzcv[FLAG_C] = shift_c;
            OP_ADD, OP_SUB: begin
                nzcv[FLAG_C] = alu_c;
                nzcv[FLAG_V] = alu_v;
            end
            default: nzcv[FLAG_V] = old_nzcv[FLAG_V];
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - two-stage architectural flag update: capture, then commit to nzcv
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid/ex_cond_pass/ex_s   execute-stage instruction qualifiers
//   ex_op, ex_result             flag class and result
//   ex_alu_c/ex_alu_v/ex_shift_c carries and overflow
//   stall                        holds the capture stage
//   msr_we, msr_data             direct flag write
//   nzcv                         architectural flags {N,Z,C,V}
//   flags_pending                a captured update has not reached nzcv yet
//   flag_writes                  saturating count of committed flag writes
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_cond_pass,
    input  logic          ex_s,
    input  logic [1:0]    ex_op,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_alu_c,
    input  logic          ex_alu_v,
    input  logic          ex_shift_c,
    input  logic          stall,
    input  logic          msr_we,
    input  logic [3:0]    msr_data,
    output logic [3:0]    nzcv,
    output logic          flags_pending,
    output logic [CW-1:0] flag_writes
);

    logic [3:0]    nzcv_q, nzcv_d;
    logic          cap_vld_q, cap_vld_d;
    logic [3:0]    cap_nzcv_q, cap_nzcv_d;
    logic [3:0]    cap_keep_q, cap_keep_d;
    logic [CW-1:0] flag_writes_q, flag_writes_d;

    logic          accept;
    logic          commit;
    logic [3:0]    calc_nzcv;
    logic [3:0]    commit_nzcv;

    flag_calc #(.DW(DW)) u_flag_calc (
        .op       (ex_op),
        .result   (ex_result),
        .alu_c    (ex_alu_c),
        .alu_v    (ex_alu_v),
        .shift_c  (ex_shift_c),
        .old_nzcv (nzcv_q),
        .nzcv     (calc_nzcv)
    );

    always_comb begin
        accept = ex_valid & ex_cond_pass & ex_s & ~stall;
        // MSR on the commit edge discards the capture instead of committing it.
        commit = cap_vld_q & ~stall & ~msr_we;

        // Passthrough flags are resolved here so they reflect nzcv at commit,
        // which may differ from capture time (back-to-back commit, MSR in a stall).
        commit_nzcv = (cap_nzcv_q & ~cap_keep_q) | (nzcv_q & cap_keep_q);

        nzcv_d = nzcv_q;
        if (msr_we) begin
            nzcv_d = msr_data;
        end else if (commit) begin
            nzcv_d = commit_nzcv;
        end

        cap_vld_d  = cap_vld_q;
        cap_nzcv_d = cap_nzcv_q;
        cap_keep_d = cap_keep_q;
        if (accept) begin
            cap_vld_d  = 1'b1;
            cap_nzcv_d = calc_nzcv;
            cap_keep_d = keep_mask(ex_op);
        end else if (cap_vld_q & ~stall) begin
            cap_vld_d = 1'b0;
        end

        flag_writes_d = flag_writes_q;
        if ((msr_we | commit) & ~(&flag_writes_q)) begin
            flag_writes_d = flag_writes_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q        <= 4'b0000;
            cap_vld_q     <= 1'b0;
            cap_nzcv_q    <= 4'b0000;
            cap_keep_q    <= 4'b0000;
            flag_writes_q <= '0;
        end else begin
            nzcv_q        <= nzcv_d;
            cap_vld_q     <= cap_vld_d;
            cap_nzcv_q    <= cap_nzcv_d;
            cap_keep_q    <= cap_keep_d;
            flag_writes_q <= flag_writes_d;
        end
    end

    assign nzcv          = nzcv_q;
    assign flags_pending = cap_vld_q;
    assign flag_writes   = flag_writes_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_cond_pass, ex_s;
    logic [1:0]  ex_op;
    logic [31:0] ex_result;
    logic        ex_alu_c, ex_alu_v, ex_shift_c;
    logic        stall, msr_we;
    logic [3:0]  msr_data;
    logic [3:0]  nzcv;
    logic        flags_pending;
    logic [7:0]  flag_writes;

    int tests_run = 0;
    int tests_failed = 0;

    flag_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_cond_pass  (ex_cond_pass),
        .ex_s          (ex_s),
        .ex_op         (ex_op),
        .ex_result     (ex_result),
        .ex_alu_c      (ex_alu_c),
        .ex_alu_v      (ex_alu_v),
        .ex_shift_c    (ex_shift_c),
        .stall         (stall),
        .msr_we        (msr_we),
        .msr_data      (msr_data),
        .nzcv          (nzcv),
        .flags_pending (flags_pending),
        .flag_writes   (flag_writes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] nzcv;
        logic       vld;
        logic [7:0] writes;
        logic       com;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [3:0]  m_nzcv;
    logic        m_vld;
    logic [1:0]  m_op;
    logic [31:0] m_res;
    logic        m_ac, m_av, m_sc;
    logic [7:0]  m_writes;

    function automatic logic [3:0] model_flags(input logic [1:0] op, input logic [31:0] res,
                                               input logic ac, input logic av, input logic sc,
                                               input logic [3:0] old);
        logic n, z;
        n = res[31];
        z = (res == 32'd0);
        case (op)
            2'b00:   return {n, z, sc, old[0]};
            2'b01:   return {n, z, ac, av};
            2'b10:   return {n, z, ac, av};
            default: return {n, z, old[1], old[0]};
        endcase
    endfunction

    function automatic logic tb_cond(input int c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !cy || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: keeps the raw captured operands and evaluates flags at commit.
    always @(posedge clk) begin : model
        logic acc, com;
        logic [3:0] nx;
        com = 1'b0;
        if (rst) begin
            m_nzcv   = 4'b0000;
            m_vld    = 1'b0;
            m_writes = 8'd0;
        end else begin
            acc = ex_valid && ex_cond_pass && ex_s && !stall;
            com = m_vld && !stall && !msr_we;
            nx  = m_nzcv;
            if (msr_we) nx = msr_data;
            else if (com) nx = model_flags(m_op, m_res, m_ac, m_av, m_sc, m_nzcv);
            if ((msr_we || com) && m_writes != 8'hFF) m_writes = m_writes + 8'd1;
            if (acc) begin
                m_vld = 1'b1;
                m_op  = ex_op;
                m_res = ex_result;
                m_ac  = ex_alu_c;
                m_av  = ex_alu_v;
                m_sc  = ex_shift_c;
            end else if (m_vld && !stall) begin
                m_vld = 1'b0;
            end
            m_nzcv = nx;
        end
        exp_q.push_back('{nzcv: m_nzcv, vld: m_vld, writes: m_writes, com: com});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (nzcv !== mon_e.nzcv || flags_pending !== mon_e.vld || flag_writes !== mon_e.writes) begin
                tests_failed++;
                $display("FAIL scoreboard t=%0t: nzcv=%b pending=%b writes=%0d, expected nzcv=%b pending=%b writes=%0d",
                         $time, nzcv, flags_pending, flag_writes, mon_e.nzcv, mon_e.vld, mon_e.writes);
            end
            if (mon_e.com) begin
                for (int c = 0; c < 16; c++) begin
                    tests_run++;
                    if (flag_unit_pkg::cond_pass(c[3:0], nzcv) !== tb_cond(c, mon_e.nzcv)) begin
                        tests_failed++;
                        $display("FAIL cond_pass[%0d] t=%0t: got %b expected %b (nzcv=%b)",
                                 c, $time, flag_unit_pkg::cond_pass(c[3:0], nzcv), tb_cond(c, mon_e.nzcv), nzcv);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_cond_pass = 0; ex_s = 0; ex_op = 2'b00; ex_result = 32'd0;
        ex_alu_c = 0; ex_alu_v = 0; ex_shift_c = 0;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] res,
                            input logic ac, input logic av, input logic sc);
        ex_valid = 1; ex_cond_pass = 1; ex_s = 1; ex_op = op; ex_result = res;
        ex_alu_c = ac; ex_alu_v = av; ex_shift_c = sc;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; msr_we = 0; msr_data = 4'b0000;
        clear_ex();
        tick(); tick();
        tests_run++;
        if (nzcv !== 4'b0000 || flags_pending !== 1'b0 || flag_writes !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset: nzcv=%b pending=%b writes=%0d, expected 0000/0/0", nzcv, flags_pending, flag_writes);
        end
    endtask

    task automatic test_add_zero();
        rst = 0;
        drive_op(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ex();
        tests_run++;
        if (flags_pending !== 1'b1 || nzcv !== 4'b0000) begin
            tests_failed++;
            $display("FAIL add_zero_capture: pending=%b nzcv=%b, expected 1/0000", flags_pending, nzcv);
        end
        tick();
        tests_run++;
        if (nzcv !== 4'b0110 || flags_pending !== 1'b0 || flag_writes !== 8'd1) begin
            tests_failed++;
            $display("FAIL add_zero_commit: nzcv=%b pending=%b writes=%0d, expected 0110/0/1", nzcv, flags_pending, flag_writes);
        end
    endtask

    task automatic test_logic_mul();
        msr_we = 1; msr_data = 4'b0001;
        tick();
        msr_we = 0;
        tests_run++;
        if (nzcv !== 4'b0001 || flag_writes !== 8'd2) begin
            tests_failed++;
            $display("FAIL msr_setup: nzcv=%b writes=%0d, expected 0001/2", nzcv, flag_writes);
        end
        drive_op(2'b00, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        tick(); clear_ex(); tick();
        tests_run++;
        if (nzcv !== 4'b1001) begin
            tests_failed++;
            $display("FAIL logic_op: nzcv=%b expected 1001", nzcv);
        end
        drive_op(2'b11, 32'd5, 1'b1, 1'b0, 1'b1);
        tick(); clear_ex(); tick();
        tests_run++;
        if (nzcv !== 4'b0001 || flag_writes !== 8'd4) begin
            tests_failed++;
            $display("FAIL mul_op: nzcv=%b writes=%0d, expected 0001/4", nzcv, flag_writes);
        end
    endtask

    task automatic test_no_update();
        drive_op(2'b01, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        ex_cond_pass = 0;
        tick();
        tests_run++;
        if (flags_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL cond_fail_pending: pending=%b expected 0", flags_pending);
        end
        ex_cond_pass = 1; ex_s = 0;
        tick();
        clear_ex();
        tests_run++;
        if (flags_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL s0_pending: pending=%b expected 0", flags_pending);
        end
        tick();
        tests_run++;
        if (nzcv !== 4'b0001 || flag_writes !== 8'd4) begin
            tests_failed++;
            $display("FAIL no_update: nzcv=%b writes=%0d, expected 0001/4", nzcv, flag_writes);
        end
    endtask

    task automatic test_stall();
        drive_op(2'b10, 32'd1, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ex();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (nzcv !== 4'b0001 || flags_pending !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: nzcv=%b pending=%b, expected 0001/1", i, nzcv, flags_pending);
            end
        end
        stall = 0;
        tick();
        tests_run++;
        if (nzcv !== 4'b0010 || flags_pending !== 1'b0 || flag_writes !== 8'd5) begin
            tests_failed++;
            $display("FAIL stall_release: nzcv=%b pending=%b writes=%0d, expected 0010/0/5", nzcv, flags_pending, flag_writes);
        end
    endtask

    task automatic test_msr_collision();
        drive_op(2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();
        clear_ex();
        msr_we = 1; msr_data = 4'b1010;
        tick();
        msr_we = 0;
        tests_run++;
        if (nzcv !== 4'b1010 || flags_pending !== 1'b0 || flag_writes !== 8'd6) begin
            tests_failed++;
            $display("FAIL msr_collision: nzcv=%b pending=%b writes=%0d, expected 1010/0/6", nzcv, flags_pending, flag_writes);
        end
        tick();
        tests_run++;
        if (nzcv !== 4'b1010 || flag_writes !== 8'd6) begin
            tests_failed++;
            $display("FAIL msr_discard: nzcv=%b writes=%0d, expected 1010/6", nzcv, flag_writes);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(2'b01, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_op(2'b10, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (nzcv !== 4'b0111 || flags_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: nzcv=%b pending=%b, expected 0111/1", nzcv, flags_pending);
        end
        drive_op(2'b00, 32'd0, 1'b1, 1'b1, 1'b1);
        tick();
        clear_ex();
        tests_run++;
        if (nzcv !== 4'b1000 || flags_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: nzcv=%b pending=%b, expected 1000/1", nzcv, flags_pending);
        end
        tick();
        tests_run++;
        if (nzcv !== 4'b0110 || flags_pending !== 1'b0 || flag_writes !== 8'd9) begin
            tests_failed++;
            $display("FAIL b2b_third: nzcv=%b pending=%b writes=%0d, expected 0110/0/9", nzcv, flags_pending, flag_writes);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_cond_pass = ($urandom_range(0, 4) != 0);
            ex_s         = ($urandom_range(0, 4) != 0);
            ex_op        = 2'($urandom_range(0, 3));
            ex_result    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            ex_alu_c     = 1'($urandom_range(0, 1));
            ex_alu_v     = 1'($urandom_range(0, 1));
            ex_shift_c   = 1'($urandom_range(0, 1));
            stall        = ($urandom_range(0, 3) == 0);
            msr_we       = ($urandom_range(0, 7) == 0);
            msr_data     = 4'($urandom_range(0, 15));
            tick();
        end
        clear_ex();
        stall = 0; msr_we = 0;
        tick(); tick();
    endtask

    task automatic test_reset_inflight();
        drive_op(2'b01, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        clear_ex();
        tests_run++;
        if (flags_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL inflight_pending: pending=%b expected 1", flags_pending);
        end
        rst = 1;
        tick();
        rst = 0;
        tests_run++;
        if (nzcv !== 4'b0000 || flags_pending !== 1'b0 || flag_writes !== 8'd0) begin
            tests_failed++;
            $display("FAIL inflight_reset: nzcv=%b pending=%b writes=%0d, expected 0000/0/0", nzcv, flags_pending, flag_writes);
        end
        tick(); tick();
        tests_run++;
        if (nzcv !== 4'b0000 || flag_writes !== 8'd0) begin
            tests_failed++;
            $display("FAIL inflight_dropped: nzcv=%b writes=%0d, expected 0000/0", nzcv, flag_writes);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            drive_op(2'($urandom_range(0, 3)), (i % 7 == 0) ? 32'd0 : $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            if (i == 254) begin
                tests_run++;
                if (flag_writes !== 8'd254) begin
                    tests_failed++;
                    $display("FAIL sat_254: writes=%0d expected 254", flag_writes);
                end
            end
        end
        clear_ex();
        tick();
        tests_run++;
        if (flag_writes !== 8'd255 || flags_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL saturation: writes=%0d pending=%b, expected 255/0", flag_writes, flags_pending);
        end
    endtask

    initial begin
        test_reset();
        test_add_zero();
        test_logic_mul();
        test_no_update();
        test_stall();
        test_msr_collision();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        test_saturation();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
